mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit between the EX/MEM and MEM/WB pipeline registers.
- Drives the data-memory bus with a req/ready handshake.
- Generates byte enables and replicated write data for SB/SH/SW.
- Aligns and sign/zero-extends load data into ReadDataM. Stalls the pipeline while memory is busy.

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_load_align.sv | 32 +++
 rtl/mem_stage_lsu.sv | 204 ++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: RV32I funct3 codes,
// FSM state encoding and the wait-counter width.
package lsu_pkg;

    localparam int CNT_W = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: picks the byte/halfword out of a bus word by the
// low address bits and sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        shifted  = word >> {byte_off, 3'b000};
        byte_val = shifted[7:0];
        half_val = byte_off[1] ? word[31:16] : word[15:0];
        // NOTE: every path assigns result (default first), so no latch is inferred.
        result   = '0;
        unique case (funct3)
            F3_B:    result = {{24{byte_val[7]}}, byte_val};
            F3_BU:   result = {24'h0, byte_val};
            F3_H:    result = {{16{half_val[15]}}, half_val};
            F3_HU:   result = {16'h0, half_val};
            F3_W:    result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: drives the data bus with req/ready, stalls while the bus is
// busy, and times out stuck accesses. Optional macro MISALIGN_TRAP_EN adds MisalignM.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = 255,
    parameter int RESET_PC_UNUSED = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        HoldM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        BusErrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
`ifdef MISALIGN_TRAP_EN
    output logic        MisalignM,
`endif
    input  logic        dmem_ready
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    if (RESET_PC_UNUSED != 0) begin : g_reserved_check
        $error("RESET_PC_UNUSED is reserved and must be 0");
    end

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       result_q, result_d;

    logic        access;
    logic        misalign;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic [31:0] load_data;
    logic [31:0] align_data;
    logic [1:0]  align_off;
    logic [2:0]  align_f3;

    assign access = MemReadM | MemWriteM;

    // Alignment follows the live instruction in IDLE and the latched copy otherwise.
    assign align_off = (state_q == IDLE) ? ALUResultM[1:0] : addr_q[1:0];
    assign align_f3  = (state_q == IDLE) ? funct3M : f3_q;

    lsu_load_align u_align (
        .word     (dmem_rdata),
        .byte_off (align_off),
        .funct3   (align_f3),
        .result   (align_data)
    );

    always_comb begin
        m_be    = 4'b1111;
        m_wdata = WriteDataM;
        if (MemWriteM) begin
            unique case (funct3M)
                F3_B: begin
                    m_be    = 4'b0001 << ALUResultM[1:0];
                    m_wdata = {4{WriteDataM[7:0]}};
                end
                F3_H: begin
                    m_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                    m_wdata = {2{WriteDataM[15:0]}};
                end
                F3_W:    m_be = 4'b1111;
                default: m_be = 4'b0000;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        if (access) begin
            unique case (funct3M)
                F3_H, F3_HU: misalign = ALUResultM[0];
                F3_W:        misalign = |ALUResultM[1:0];
                default:     misalign = 1'b0;
            endcase
        end
    end
    assign MisalignM = misalign;
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        f3_d       = f3_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        result_d   = result_q;
        load_data  = '0;
        StallM     = 1'b0;
        BusErrM    = 1'b0;
        ReadDataM  = '0;
        dmem_req   = 1'b0;
        dmem_we    = we_q;
        dmem_addr  = {addr_q[31:2], 2'b00};
        dmem_be    = be_q;
        dmem_wdata = wdata_q;

        unique case (state_q)
            IDLE: begin
                dmem_we    = MemWriteM;
                dmem_addr  = {ALUResultM[31:2], 2'b00};
                dmem_be    = m_be;
                dmem_wdata = m_wdata;
                if (access && !misalign) begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        load_data = MemWriteM ? '0 : align_data;
                        ReadDataM = load_data;
                        result_d  = load_data;
                        if (HoldM) state_d = DONE;
                    end else begin
                        StallM  = 1'b1;
                        addr_d  = ALUResultM;
                        f3_d    = funct3M;
                        we_d    = MemWriteM;
                        be_d    = m_be;
                        wdata_d = m_wdata;
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    load_data = we_q ? '0 : align_data;
                    ReadDataM = load_data;
                    result_d  = load_data;
                    cnt_d     = '0;
                    state_d   = HoldM ? DONE : IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // Forced completion: store is dropped, load returns zero.
                    BusErrM  = 1'b1;
                    result_d = '0;
                    cnt_d    = '0;
                    state_d  = HoldM ? DONE : IDLE;
                end else begin
                    StallM = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            DONE: begin
                ReadDataM = result_q;
                if (!HoldM) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // No bus request or stall may be visible while reset is asserted.
        if (!rst_n) begin
            dmem_req = 1'b0;
            StallM   = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            f3_q     <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            f3_q     <= f3_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (timeout shortened to 4 cycles).
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemReadM, MemWriteM, HoldM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic        StallM, BusErrM;
    logic [31:0] ReadDataM;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
`ifdef MISALIGN_TRAP_EN
    logic        MisalignM;
`endif

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rst_n && dmem_req && dmem_ready) xfer_cnt++;

    mem_stage_lsu #(.TIMEOUT_CYCLES(4), .RESET_PC_UNUSED(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .HoldM      (HoldM),
        .StallM     (StallM),
        .ReadDataM  (ReadDataM),
        .BusErrM    (BusErrM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
`ifdef MISALIGN_TRAP_EN
        .MisalignM  (MisalignM),
`endif
        .dmem_ready (dmem_ready)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        HoldM      = 1'b0;
        funct3M    = 3'b000;
        ALUResultM = '0;
        WriteDataM = '0;
        dmem_rdata = '0;
        dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #3;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", dmem_req); end
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", StallM); end
        checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", ReadDataM); end
        checks++; if (BusErrM !== 1'b0) begin errors++; $display("FAIL reset_buserr: got %b want 0", BusErrM); end
        #9 rst_n = 1'b1;
    endtask

    task automatic test_stores();
        cyc();
        MemWriteM = 1'b1; funct3M = 3'b000; ALUResultM = 32'h1003; WriteDataM = 32'h000000AB; dmem_ready = 1'b1;
        #1;
        checks++; if (dmem_be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b want 1000", dmem_be); end
        checks++; if (dmem_wdata !== 32'hABABABAB) begin errors++; $display("FAIL sb_wdata: got %h want ababab ab", dmem_wdata); end
        checks++; if (dmem_addr !== 32'h1000) begin errors++; $display("FAIL sb_addr: got %h want 00001000", dmem_addr); end
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL sb_stall: got %b want 0", StallM); end
        checks++; if ({dmem_req, dmem_we} !== 2'b11) begin errors++; $display("FAIL sb_req_we: got %b want 11", {dmem_req, dmem_we}); end
        cyc();
        funct3M = 3'b001; ALUResultM = 32'h1002; WriteDataM = 32'h12345678;
        #1;
        checks++; if (dmem_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b want 1100", dmem_be); end
        checks++; if (dmem_wdata !== 32'h56785678) begin errors++; $display("FAIL sh_wdata: got %h want 56785678", dmem_wdata); end
        cyc();
        funct3M = 3'b010; ALUResultM = 32'h0004; WriteDataM = 32'hDEADBEEF;
        #1;
        checks++; if (dmem_be !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b want 1111", dmem_be); end
        checks++; if (dmem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h want deadbeef", dmem_wdata); end
        cyc();
        funct3M = 3'b011;
        #1;
        checks++; if (dmem_be !== 4'b0000) begin errors++; $display("FAIL sbad_be: got %b want 0000", dmem_be); end
        cyc();
        MemReadM = 1'b1; funct3M = 3'b010;
        #1;
        checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL rw_we: got %b want 1", dmem_we); end
        checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL rw_rdata: got %h want 0", ReadDataM); end
        cyc();
        idle_inputs();
    endtask

    task automatic test_load_ext();
        cyc();
        MemReadM = 1'b1; dmem_ready = 1'b1; dmem_rdata = 32'h8765F0E1;
        funct3M = 3'b001; ALUResultM = 32'h0102;
        #1;
        checks++; if (ReadDataM !== 32'hFFFF8765) begin errors++; $display("FAIL lh_hi: got %h want ffff8765", ReadDataM); end
        checks++; if (dmem_be !== 4'b1111) begin errors++; $display("FAIL load_be: got %b want 1111", dmem_be); end
        cyc();
        funct3M = 3'b101; ALUResultM = 32'h0100;
        #1;
        checks++; if (ReadDataM !== 32'h0000F0E1) begin errors++; $display("FAIL lhu_lo: got %h want 0000f0e1", ReadDataM); end
        cyc();
        funct3M = 3'b000;
        #1;
        checks++; if (ReadDataM !== 32'hFFFFFFE1) begin errors++; $display("FAIL lb_b0: got %h want ffffffe1", ReadDataM); end
        cyc();
        funct3M = 3'b010;
        #1;
        checks++; if (ReadDataM !== 32'h8765F0E1) begin errors++; $display("FAIL lw: got %h want 8765f0e1", ReadDataM); end
        cyc();
        funct3M = 3'b011;
        #1;
        checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL lbad: got %h want 0", ReadDataM); end
        cyc();
        idle_inputs();
    endtask

    task automatic test_load_wait(input logic [2:0] f3, input logic [31:0] want, input string name);
        cyc();
        MemReadM = 1'b1; funct3M = f3; ALUResultM = 32'h2001; dmem_rdata = 32'h00008000; dmem_ready = 1'b0;
        #1;
        checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL %s_stall0: got %b want 1", name, StallM); end
        checks++; if (dmem_addr !== 32'h2000) begin errors++; $display("FAIL %s_addr0: got %h want 00002000", name, dmem_addr); end
        for (int i = 1; i < 3; i++) begin
            cyc();
            ALUResultM = 32'hFFFFFFFC;
            #1;
            checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL %s_stall%0d: got %b want 1", name, i, StallM); end
            checks++; if ({dmem_req, dmem_addr, dmem_be} !== {1'b1, 32'h2000, 4'hF}) begin
                errors++; $display("FAIL %s_bus%0d: got req=%b addr=%h be=%b want 1/00002000/1111", name, i, dmem_req, dmem_addr, dmem_be);
            end
        end
        cyc();
        dmem_ready = 1'b1;
        #1;
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL %s_stall_rdy: got %b want 0", name, StallM); end
        checks++; if (ReadDataM !== want) begin errors++; $display("FAIL %s_data: got %h want %h", name, ReadDataM, want); end
        cyc();
        idle_inputs();
        #1;
        checks++; if ({dmem_req, ReadDataM} !== 33'h0) begin errors++; $display("FAIL %s_after: got req=%b data=%h want 0/0", name, dmem_req, ReadDataM); end
    endtask

    task automatic test_hold_done();
        int start;
        cyc();
        start = xfer_cnt;
        MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h40; dmem_rdata = 32'h11223344; dmem_ready = 1'b1; HoldM = 1'b1;
        #1;
        checks++; if ({StallM, ReadDataM} !== {1'b0, 32'h11223344}) begin errors++; $display("FAIL hold_first: got stall=%b data=%h want 0/11223344", StallM, ReadDataM); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            dmem_rdata = 32'hBAD0BAD0;
            if (i == 2) HoldM = 1'b0;
            #1;
            checks++; if ({dmem_req, StallM, ReadDataM} !== {2'b00, 32'h11223344}) begin
                errors++; $display("FAIL hold_done%0d: got req=%b stall=%b data=%h want 0/0/11223344", i, dmem_req, StallM, ReadDataM);
            end
        end
        cyc();
        idle_inputs();
        #1;
        checks++; if (xfer_cnt - start !== 1) begin errors++; $display("FAIL hold_xfers: got %0d want 1", xfer_cnt - start); end
    endtask

    task automatic test_timeout();
        cyc();
        MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h80; dmem_rdata = 32'h55555555; dmem_ready = 1'b0;
        #1;
        checks++; if ({StallM, BusErrM} !== 2'b10) begin errors++; $display("FAIL to_issue: got stall/err=%b want 10", {StallM, BusErrM}); end
        for (int i = 1; i < 4; i++) begin
            cyc();
            #1;
            checks++; if ({StallM, BusErrM} !== 2'b10) begin errors++; $display("FAIL to_wait%0d: got stall/err=%b want 10", i, {StallM, BusErrM}); end
        end
        cyc();
        #1;
        checks++; if ({StallM, BusErrM, ReadDataM} !== {2'b01, 32'h0}) begin
            errors++; $display("FAIL to_fire: got stall=%b err=%b data=%h want 0/1/0", StallM, BusErrM, ReadDataM);
        end
        cyc();
        idle_inputs();
        #1;
        checks++; if (BusErrM !== 1'b0) begin errors++; $display("FAIL to_pulse: got %b want 0", BusErrM); end
    endtask

    task automatic test_reset_mid();
        cyc();
        MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'hC0; dmem_ready = 1'b0;
        cyc();
        checks++; if ({dmem_req, StallM} !== 2'b11) begin errors++; $display("FAIL rst_wait: got req/stall=%b want 11", {dmem_req, StallM}); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({dmem_req, StallM} !== 2'b00) begin errors++; $display("FAIL rst_async: got req/stall=%b want 00", {dmem_req, StallM}); end
        idle_inputs();
        cyc();
        #2 rst_n = 1'b1;
        cyc();
        MemWriteM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h10; WriteDataM = 32'hCAFEF00D; dmem_ready = 1'b1;
        #1;
        checks++; if ({dmem_req, dmem_we, dmem_be, StallM} !== {2'b11, 4'hF, 1'b0}) begin
            errors++; $display("FAIL rst_sw_ctl: got req=%b we=%b be=%b stall=%b want 1/1/1111/0", dmem_req, dmem_we, dmem_be, StallM);
        end
        checks++; if ({dmem_addr, dmem_wdata} !== {32'h10, 32'hCAFEF00D}) begin
            errors++; $display("FAIL rst_sw_bus: got addr=%h wdata=%h want 00000010/cafef00d", dmem_addr, dmem_wdata);
        end
        cyc();
        idle_inputs();
    endtask

    task automatic test_misalign();
        cyc();
        MemReadM = 1'b1; funct3M = 3'b001; ALUResultM = 32'h3; dmem_rdata = 32'hBEEF1234; dmem_ready = 1'b1;
        #1;
`ifdef MISALIGN_TRAP_EN
        checks++; if ({MisalignM, dmem_req, StallM} !== 3'b100) begin
            errors++; $display("FAIL mis_trap: got mis=%b req=%b stall=%b want 1/0/0", MisalignM, dmem_req, StallM);
        end
        checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL mis_data: got %h want 0", ReadDataM); end
`else
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL mis_req: got %b want 1", dmem_req); end
        checks++; if (ReadDataM !== 32'hFFFFBEEF) begin errors++; $display("FAIL mis_data: got %h want ffffbeef", ReadDataM); end
`endif
        cyc();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_stores();
        test_load_ext();
        test_load_wait(3'b000, 32'hFFFFFF80, "lb_wait");
        test_load_wait(3'b100, 32'h00000080, "lbu_wait");
        test_hold_done();
        test_timeout();
        test_reset_mid();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
